// File: rtl/count_dir_ctrl_if.sv
// Button/prescaler control bundle between the stimulus side and count_dir_ctrl.
// The master drives the button, enable and counter feedback; the slave returns the direction, tick and press pulses.
interface count_dir_ctrl_if;
    logic       btn_i;
    logic       en_i;
    logic [3:0] count_i;
    logic       sel_o;
    logic       tick_o;
    logic       press_o;

    modport master (
        output btn_i, en_i, count_i,
        input  sel_o, tick_o, press_o
    );

    modport slave (
        input  btn_i, en_i, count_i,
        output sel_o, tick_o, press_o
    );
endinterface

// File: rtl/count_dir_ctrl.sv
// Debounced direction toggle plus count-enable prescaler for an up/down counter; optional COUNT_DIR_AUTO_BOUNCE_EN flips direction at 4'hF/4'h0.
// Latency: press_o DEBOUNCE_CYC+3 cycles after a clean btn_i rise; first tick_o PRESCALE+1 cycles after reset release.
// Backpressure: none; en_i only freezes the prescaler, and every output is a registered pulse or level.
module count_dir_ctrl #(
    parameter int DEBOUNCE_CYC = 16,
    parameter int PRESCALE     = 8
) (
    input logic           clk_i,
    input logic           rst_i,
    count_dir_ctrl_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYC);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, ARM, HELD, DISARM} state_e;

    logic          sync1_q, sync2_q;
    logic          btn_s;
    state_e        state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          press_q, press_d;
    logic          sel_q, sel_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          wrap_q, wrap_d;
    logic          tick_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.btn_i;
            sync2_q <= sync1_q;
        end
    end

    assign btn_s = sync2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = ARM;
                    dcnt_d  = '0;
                end
            end
            ARM: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == DB_LAST) begin
                    state_d = HELD;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = DISARM;
                    dcnt_d  = '0;
                end
            end
            DISARM: begin
                if (btn_s) begin
                    state_d = HELD;
                    dcnt_d  = '0;
                end else if (dcnt_q == DB_LAST) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                dcnt_d  = '0;
            end
        endcase
    end

    // Press is accepted on the ARM->HELD transition; release never pulses.
    always_comb begin
        press_d = (state_q == ARM) && btn_s && (dcnt_q == DB_LAST);
    end

`ifdef COUNT_DIR_AUTO_BOUNCE_EN
    // Limit flips take priority over a coincident press toggle.
    always_comb begin
        sel_d = sel_q;
        if (sel_q && (bus.count_i == 4'hF)) begin
            sel_d = 1'b0;
        end else if (!sel_q && (bus.count_i == 4'h0)) begin
            sel_d = 1'b1;
        end else if (press_d) begin
            sel_d = ~sel_q;
        end
    end
`else
    logic unused_count;
    assign unused_count = ^bus.count_i;

    always_comb begin
        sel_d = sel_q;
        if (press_d) begin
            sel_d = ~sel_q;
        end
    end
`endif

    always_comb begin
        pre_d  = pre_q;
        wrap_d = 1'b0;
        if (bus.en_i) begin
            wrap_d = (pre_q == PS_LAST);
            pre_d  = (pre_q == PS_LAST) ? '0 : pre_q + 1'b1;
        end
    end

    // tick trails the wrap by one cycle so it lands in the cycle after the wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            press_q <= 1'b0;
            sel_q   <= 1'b1;
            pre_q   <= '0;
            wrap_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            press_q <= press_d;
            sel_q   <= sel_d;
            pre_q   <= pre_d;
            wrap_q  <= wrap_d;
            tick_q  <= wrap_q;
        end
    end

    assign bus.sel_o   = sel_q;
    assign bus.tick_o  = tick_q;
    assign bus.press_o = press_q;
endmodule

// File: doc/count_dir_ctrl.md
COUNT_DIR_CTRL -- requirements
Module: count_dir_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 16: consecutive stable synchronized cycles needed to accept a button level change; legal range 2..1024.
REQ-002 Parameter PRESCALE, default 8: clock cycles per count-enable tick; legal range 2..65536.
REQ-003 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 btn_i  input  1  raw, asynchronous, bouncing push button; 1 = pressed.
REQ-006 en_i  input  1  prescaler run enable; 1 = run.
REQ-007 count_i  input  4  current value fed back from the downstream up/down counter.
REQ-008 sel_o  output  1  direction select to the counter; 1 = up, 0 = down; driven from a register.
REQ-009 tick_o  output  1  one-cycle count-enable pulse to the counter; driven from a register.
REQ-010 press_o  output  1  one-cycle pulse for each accepted button press; driven from a register.

Function
REQ-011 btn_i shall pass through a two-flop synchronizer; the debouncer shall use only the second flop (btn_s).
REQ-012 Debouncer FSM states: IDLE (released), ARM (press pending), HELD (pressed), DISARM (release pending).
REQ-013 IDLE->ARM when btn_s=1, with the debounce counter cleared.
REQ-014 In ARM, when btn_s=1 the counter increments; when btn_s=0 the FSM returns to IDLE and the counter clears.
REQ-015 ARM->HELD in the cycle in which btn_s=1 and counter=DEBOUNCE_CYC-1; press_o=1 in the following cycle only.
REQ-016 HELD->DISARM when btn_s=0; DISARM->IDLE after DEBOUNCE_CYC consecutive btn_s=0 cycles; btn_s=1 in DISARM returns to HELD; no pulse on release.
REQ-017 Latency from a clean btn_i rise to press_o shall be DEBOUNCE_CYC+3 cycles.
REQ-018 Each press_o pulse shall toggle sel_o; the new value is visible in the same cycle as press_o.
REQ-019 The prescaler shall count 0..PRESCALE-1 while en_i=1 and hold its value while en_i=0.
REQ-020 tick_o shall be 1 for exactly the one cycle after the prescaler wraps from PRESCALE-1 to 0, and 0 otherwise; en_i=0 suppresses new ticks.
REQ-021 A tick_o pulse and a sel_o change in the same cycle are legal; the counter applies the sel_o value present in that cycle.
REQ-022 Button and prescaler logic shall be independent: a press never resets or stalls the prescaler.

Reset
REQ-023 When rst_i=1 at a clock edge: sel_o=1, tick_o=0, press_o=0, FSM=IDLE, debounce and prescaler counters=0, synchronizer flops=0.
REQ-024 Reset asserted mid-debounce or mid-prescale shall discard the partial count; no press_o or tick_o pulse follows reset.
REQ-025 After rst_i deasserts, the first tick_o shall occur PRESCALE+1 cycles later, given en_i=1 throughout.

Configuration
REQ-026 When COUNT_DIR_AUTO_BOUNCE_EN is defined, sel_o shall be forced to 0 on the cycle after count_i=4'hF with sel_o=1, and forced to 1 on the cycle after count_i=4'h0 with sel_o=0.
REQ-027 When COUNT_DIR_AUTO_BOUNCE_EN is defined and a limit flip coincides with a press toggle, the limit flip shall win; press_o still pulses.
REQ-028 When COUNT_DIR_AUTO_BOUNCE_EN is undefined, count_i shall be ignored and sel_o shall change only on press_o; the counter wraps 15->0 and 0->15.

Verification
REQ-029 Reset, en_i=1, PRESCALE=8 -> tick_o pulses at cycles 9, 17, 25 after reset release; sel_o=1 throughout.
REQ-030 btn_i held at 1 cleanly, DEBOUNCE_CYC=16 -> single press_o at cycle 19; sel_o goes 1->0 in the same cycle.
REQ-031 btn_i toggling every 5 cycles for 100 cycles, then held at 0 -> no press_o pulse and sel_o unchanged.
REQ-032 en_i=0 for 20 cycles mid-count -> no tick_o pulses; the prescaler resumes from its held value and the next tick arrives on schedule.
REQ-033 COUNT_DIR_AUTO_BOUNCE_EN defined, count_i=4'hF, sel_o=1 -> sel_o=0 next cycle; with undefined macro -> sel_o stays 1.
REQ-034 rst_i pulsed at debounce count 10 while the button is held -> press_o pulses only after a further DEBOUNCE_CYC+3 cycles.
